// File: rtl/scan_frame_packer_pkg.sv
// Shared definitions for the A-scan frame packer: default frame constants,
// FSM state encoding and a saturating counter helper.
package scan_frame_packer_pkg;

    localparam logic [15:0] HDR_WORD_DEF  = 16'hA55A;
    localparam int          FRAME_LEN_DEF = 512;
    localparam int          USEDW_W_DEF   = 11;
    localparam int          HIGH_WM_DEF   = 1900;

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_HDR0 = 3'd1,
        ST_HDR1 = 3'd2,
        ST_HDR2 = 3'd3,
        ST_DATA = 3'd4,
        ST_CSUM = 3'd5
    } state_t;

    function automatic logic [15:0] sat_inc16(input logic [15:0] v);
        return (v == 16'hFFFF) ? v : v + 16'd1;
    endfunction

endpackage

// File: rtl/scan_frame_packer_csum16.sv
// Frame checksum accumulator: clear at frame start, add each written sample,
// present the bitwise complement of the running 16-bit sum.
module scan_frame_packer_csum16 (
    input  logic        Clk,
    input  logic        Rst_n,
    input  logic        clear,
    input  logic        acc_en,
    input  logic [15:0] data,
    output logic [15:0] csum
);

    logic [15:0] sum;

    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            sum <= 16'd0;
        end else if (clear) begin
            sum <= 16'd0;
        end else if (acc_en) begin
            sum <= sum + data;
        end
    end

    assign csum = ~sum;

endmodule

// File: rtl/scan_frame_packer.sv
// Packs ADC samples into A-scan frames (sync, position/seq, length, samples,
// checksum) for the USB upload FIFO; never stalls the ADC, drops on high-water.
//
// state | meaning
// IDLE  | not armed; waiting for start
// HDR0  | write sync word (stalls without room)
// HDR1  | write {position, seq} (stalls without room)
// HDR2  | write frame length, reset checksum and sample counter
// DATA  | write valid samples while room, count drops otherwise
// CSUM  | write complemented checksum, then next frame or idle
module scan_frame_packer
    import scan_frame_packer_pkg::*;
#(
    parameter int          FRAME_LEN = FRAME_LEN_DEF,
    parameter logic [15:0] HDR_WORD  = HDR_WORD_DEF,
    parameter int          USEDW_W   = USEDW_W_DEF,
    parameter int          HIGH_WM   = HIGH_WM_DEF
) (
    input  logic               Clk,
    input  logic               Rst_n,
    input  logic               start,
    input  logic               stop,
    input  logic [15:0]        num_frames,
    input  logic [15:0]        sample_data,
    input  logic               sample_valid,
    input  logic [7:0]         position,
    input  logic [USEDW_W-1:0] usb_fifo_usedw,
    output logic               usb_fifo_wrreq,
    output logic [15:0]        usb_fifo_wrdata,
    output logic               busy,
    output logic [15:0]        drop_cnt,
    output logic               overflow
);

    localparam logic [15:0] FRAME_LEN_W = 16'(FRAME_LEN);

    state_t      state;
    state_t      state_nxt;
    logic        room;
    logic [15:0] frames_left;
    logic [15:0] samples_left;
    logic [7:0]  seq;
    logic        stop_seen;
    logic        stop_now;
    logic [15:0] csum;

    logic        load_run;
    logic        wr_en;
    logic [15:0] wr_val;
    logic        len_en;
    logic        acc_en;
    logic        drop_en;
    logic        trl_en;
    logic        run_end;

    assign room     = (32'(usb_fifo_usedw) < HIGH_WM);
    // a stop arriving in the very cycle the checksum goes out still ends the run
    assign stop_now = stop_seen | stop;

    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE: if (start) state_nxt = ST_HDR0;
            ST_HDR0: if (room) state_nxt = ST_HDR1;
            ST_HDR1: if (room) state_nxt = ST_HDR2;
            ST_HDR2: if (room) state_nxt = ST_DATA;
            ST_DATA: begin
                if (sample_valid && room && samples_left == 16'd1) begin
                    state_nxt = ST_CSUM;
                end
            end
            ST_CSUM: begin
                if (room) begin
                    state_nxt = (stop_now || frames_left == 16'd1) ? ST_IDLE : ST_HDR0;
                end
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    always_comb begin
        load_run = 1'b0;
        wr_en    = 1'b0;
        wr_val   = 16'd0;
        len_en   = 1'b0;
        acc_en   = 1'b0;
        drop_en  = 1'b0;
        trl_en   = 1'b0;
        run_end  = 1'b0;
        case (state)
            ST_IDLE: load_run = start;
            ST_HDR0: begin
                wr_en  = room;
                wr_val = HDR_WORD;
            end
            ST_HDR1: begin
                wr_en  = room;
                wr_val = {position, seq};
            end
            ST_HDR2: begin
                wr_en  = room;
                wr_val = FRAME_LEN_W;
                len_en = room;
            end
            ST_DATA: begin
                wr_val = sample_data;
                if (sample_valid) begin
                    wr_en   = room;
                    acc_en  = room;
                    drop_en = !room;
                end
            end
            ST_CSUM: begin
                wr_en   = room;
                wr_val  = csum;
                trl_en  = room;
                run_end = room && (stop_now || frames_left == 16'd1);
            end
            default: ;
        endcase
    end

    scan_frame_packer_csum16 u_csum (
        .Clk    (Clk),
        .Rst_n  (Rst_n),
        .clear  (len_en),
        .acc_en (acc_en),
        .data   (sample_data),
        .csum   (csum)
    );

    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            usb_fifo_wrreq  <= 1'b0;
            usb_fifo_wrdata <= 16'd0;
            busy            <= 1'b0;
            drop_cnt        <= 16'd0;
            overflow        <= 1'b0;
            frames_left     <= 16'd0;
            samples_left    <= 16'd0;
            seq             <= 8'd0;
            stop_seen       <= 1'b0;
        end else begin
            usb_fifo_wrreq <= wr_en;
            if (wr_en) begin
                usb_fifo_wrdata <= wr_val;
            end

            if (load_run) begin
                busy        <= 1'b1;
                frames_left <= num_frames;
                drop_cnt    <= 16'd0;
                overflow    <= 1'b0;
                stop_seen   <= stop;
            end else if (state != ST_IDLE && stop) begin
                stop_seen <= 1'b1;
            end

            if (len_en) begin
                samples_left <= FRAME_LEN_W;
            end else if (acc_en) begin
                samples_left <= samples_left - 16'd1;
            end

            if (drop_en) begin
                drop_cnt <= sat_inc16(drop_cnt);
                overflow <= 1'b1;
            end

            // frames_left of 0 means continuous and is never decremented
            if (trl_en) begin
                seq <= seq + 8'd1;
                if (run_end) begin
                    busy <= 1'b0;
                end else if (frames_left != 16'd0) begin
                    frames_left <= frames_left - 16'd1;
                end
            end
        end
    end

endmodule
